conv_window_sequencer: RTL and testbench

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_window_sequencer_if.sv | 30 +++
 rtl/conv_lat_tag.sv | 34 +++
 rtl/conv_window_sequencer.sv | 107 ++++++++++
 tb/tb_conv_window_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution window sequencer: fp16 element, tile,
// window and output-map shapes, and the sequencer FSM state encoding.
package conv_pkg;
  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;
  typedef fp16_t [15:0]      tile_t;
  typedef fp16_t [8:0]       window_t;
  typedef fp16_t [3:0]       ofmap_t;
  typedef logic [1:0]        pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/conv_window_sequencer_if.sv
// Tile-in / window-out / ofmap-out signal bundle of the window sequencer.
interface conv_window_sequencer_if
  import conv_pkg::*;
#(
  parameter int DATA_W = FP16_W
);
  // A transfer happens on a rising edge where valid && ready; the source holds
  // data stable while valid is high, and ready never depends on valid.
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0][DATA_W-1:0]  ifmap_4x4;
  logic [8:0][DATA_W-1:0]   weight_in;
  logic [8:0][DATA_W-1:0]   window;
  logic [8:0][DATA_W-1:0]   weight_3x3;
  logic                     win_valid;
  logic [DATA_W-1:0]        result;
  logic [3:0][DATA_W-1:0]   ofmap;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  in_valid, ifmap_4x4, weight_in, result, out_ready,
    output in_ready, window, weight_3x3, win_valid, ofmap, out_valid
  );

  modport master (
    output in_valid, ifmap_4x4, weight_in, result, out_ready,
    input  in_ready, window, weight_3x3, win_valid, ofmap, out_valid
  );
endinterface

// File: rtl/conv_lat_tag.sv
// Delay line that tracks which output position a window belongs to while the
// external kernel computes it: valid bit plus 2-bit position, DEPTH stages.
module conv_lat_tag
  import conv_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  pos_t idx,
  output logic valid_d,
  output pos_t idx_d
);
  logic [DEPTH-1:0] v_sr;
  pos_t             i_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr <= '0;
      for (int s = 0; s < DEPTH; s++) i_sr[s] <= '0;
    end else begin
      v_sr[0] <= valid;
      i_sr[0] <= idx;
      for (int s = 1; s < DEPTH; s++) begin
        v_sr[s] <= v_sr[s-1];
        i_sr[s] <= i_sr[s-1];
      end
    end
  end

  assign valid_d = v_sr[DEPTH-1];
  assign idx_d   = i_sr[DEPTH-1];
endmodule

// File: rtl/conv_window_sequencer.sv
// Captures a 4x4 tile and 3x3 kernel, streams the four 3x3 windows to an
// external fixed-latency kernel, and gathers its results into a 2x2 ofmap.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int KERNEL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_window_sequencer_if.slave  bus,
  output state_t                  dbg_state
);
  state_t                  state;
  pos_t                    idx;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    last_q;
  logic [15:0][DATA_W-1:0] tile_q;
  logic [8:0][DATA_W-1:0]  kern_q;
  logic [3:0][DATA_W-1:0]  ofmap_q;
  logic [8:0][DATA_W-1:0]  win_c;
  logic [3:0]              base;
  logic                    issue;
  logic                    tag_v;
  pos_t                    tag_idx;

  assign issue = (state == ISSUE);

  conv_lat_tag #(.DEPTH(KERNEL_LAT)) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (issue),
    .idx     (idx),
    .valid_d (tag_v),
    .idx_d   (tag_idx)
  );

  // Window origin is row idx[1], column idx[0] of the captured tile.
  always_comb begin
    win_c = '0;
    base  = {1'b0, idx[1], 2'b00} + {3'b000, idx[0]};
    if (issue) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_c[4'(3*i + j)] = tile_q[base + 4'(4*i + j)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      tile_q      <= '0;
      kern_q      <= '0;
      ofmap_q     <= '0;
    end else begin
      if (tag_v) ofmap_q[tag_idx] <= bus.result;
      // One cycle of slack after the final result lands before DONE.
      last_q <= tag_v && (tag_idx == 2'd3);
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            tile_q     <= bus.ifmap_4x4;
            kern_q     <= bus.weight_in;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= ISSUE;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= DRAIN;
        end
        DRAIN: begin
          if (last_q) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.window     = win_c;
  assign bus.win_valid  = issue;
  assign bus.weight_3x3 = kern_q;
  assign bus.ofmap      = ofmap_q;
  assign bus.out_valid  = out_valid_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer at KERNEL_LAT 3, 1 and 5, with a
// real-valued fp16 dot-product kernel model behind each instance.
module tb_conv_window_sequencer;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_sequencer_if #(.DATA_W(16)) b3 ();
  conv_window_sequencer_if #(.DATA_W(16)) b1 ();
  conv_window_sequencer_if #(.DATA_W(16)) b5 ();
  state_t d3, d1, d5;

  conv_window_sequencer #(.DATA_W(16), .KERNEL_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3), .dbg_state(d3));
  conv_window_sequencer #(.DATA_W(16), .KERNEL_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(d1));
  conv_window_sequencer #(.DATA_W(16), .KERNEL_LAT(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5), .dbg_state(d5));

  // index 0 drives the KERNEL_LAT=1 instance, index 1 the KERNEL_LAT=5 one
  logic    x_valid [2];
  tile_t   x_tile  [2];
  window_t x_wt    [2];
  logic    x_ordy;
  logic    x_rdy   [2];
  logic    x_ov    [2];
  ofmap_t  x_of    [2];

  assign b1.in_valid = x_valid[0];  assign b5.in_valid = x_valid[1];
  assign b1.ifmap_4x4 = x_tile[0];  assign b5.ifmap_4x4 = x_tile[1];
  assign b1.weight_in = x_wt[0];    assign b5.weight_in = x_wt[1];
  assign b1.out_ready = x_ordy;     assign b5.out_ready = x_ordy;
  assign x_rdy[0] = b1.in_ready;    assign x_rdy[1] = b5.in_ready;
  assign x_ov[0]  = b1.out_valid;   assign x_ov[1]  = b5.out_valid;
  assign x_of[0]  = b1.ofmap;       assign x_of[1]  = b5.ofmap;

  function automatic real pw2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * pw2(-24);
    else        m = real'({1'b1, h[9:0]}) * pw2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2fp(input real x);
    real  a;
    int   e;
    int   m;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e + 15 <= 0) begin
      m = $rtoi((s ? -x : x) * pw2(24) + 0.5);
      return {s, 5'd0, m[9:0]};
    end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    if (e + 15 >= 31) return {s, 5'h1f, 10'h000};
    return {s, 5'(e + 15), m[9:0]};
  endfunction

  function automatic logic [15:0] dot9(input window_t w, input window_t k);
    real acc = 0.0;
    for (int i = 0; i < 9; i++) acc = acc + fp2r(w[i]) * fp2r(k[i]);
    return r2fp(acc);
  endfunction

  logic [15:0] k3 [3];
  logic [15:0] k1 [1];
  logic [15:0] k5 [5];
  always @(posedge clk) begin
    k3[0] <= dot9(b3.window, b3.weight_3x3);
    for (int s = 1; s < 3; s++) k3[s] <= k3[s-1];
    k1[0] <= dot9(b1.window, b1.weight_3x3);
    k5[0] <= dot9(b5.window, b5.weight_3x3);
    for (int s = 1; s < 5; s++) k5[s] <= k5[s-1];
  end
  assign b3.result = k3[2];
  assign b1.result = k1[0];
  assign b5.result = k5[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tile_t fill_tile(input logic [15:0] v);
    tile_t t;
    for (int k = 0; k < 16; k++) t[4'(k)] = v;
    return t;
  endfunction

  function automatic window_t fill_win(input logic [15:0] v);
    window_t w;
    for (int k = 0; k < 9; k++) w[4'(k)] = v;
    return w;
  endfunction

  // Three tiles back to back on one of the extra instances, out_ready held 1.
  task automatic b2b(input int s, input int lat);
    logic [15:0] vals [3];
    logic [15:0] exps [3];
    int hs;
    int n;
    vals[0] = 16'h3C00; exps[0] = 16'h4880;
    vals[1] = 16'h4000; exps[1] = 16'h4C80;
    vals[2] = 16'h3800; exps[2] = 16'h4480;
    x_wt[s] = fill_win(16'h3C00);
    n = 0;
    while (!x_rdy[s] && n < 20) begin tick(); n++; end
    chk($sformatf("b2b%0d_idle_rdy", lat), x_rdy[s], 1'b1);
    x_valid[s] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      x_tile[s] = fill_tile(vals[t]);
      tick();
      hs = cyc;
      while (!x_ov[s] && (cyc - hs) < 40) tick();
      chk($sformatf("b2b%0d_t%0d_lat", lat, t), cyc - hs, 4 + lat + 1);
      chk($sformatf("b2b%0d_t%0d_ofmap", lat, t), x_of[s], {4{exps[t]}});
      tick();
      chk($sformatf("b2b%0d_t%0d_rdy", lat, t), x_rdy[s], 1'b1);
    end
    x_valid[s] = 1'b0;
  endtask

  initial begin
    tile_t   tk;
    window_t wc;
    int      hs;
    int      seen;

    rst_n = 1'b1;
    b3.in_valid = 1'b0; b3.ifmap_4x4 = '0; b3.weight_in = '0; b3.out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin x_valid[s] = 1'b0; x_tile[s] = '0; x_wt[s] = '0; end
    x_ordy = 1'b1;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", b3.in_ready, 1'b0);
    chk("rst_win_valid", b3.win_valid, 1'b0);
    chk("rst_window", b3.window, '0);
    chk("rst_out_valid", b3.out_valid, 1'b0);
    chk("rst_ofmap", b3.ofmap, '0);
    chk("rst_weight", b3.weight_3x3, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rdy_before_edge", b3.in_ready, 1'b0);
    tick();
    chk("rdy_after_edge", b3.in_ready, 1'b1);

    // window mapping: element k = k, only the centre weight is 1.0
    for (int k = 0; k < 16; k++) tk[4'(k)] = 16'(k);
    wc = '0; wc[4] = 16'h3C00;
    b3.ifmap_4x4 = tk; b3.weight_in = wc; b3.in_valid = 1'b1;
    tick();
    hs = cyc;
    b3.in_valid = 1'b0;
    chk("map_p0_win_valid", b3.win_valid, 1'b1);
    chk("map_p0_window", b3.window,
        {16'hA, 16'h9, 16'h8, 16'h6, 16'h5, 16'h4, 16'h2, 16'h1, 16'h0});
    chk("map_in_ready_busy", b3.in_ready, 1'b0);
    chk("map_weight", b3.weight_3x3, wc);
    tick(); tick();
    chk("map_p2_win_valid", b3.win_valid, 1'b1);
    tick();
    chk("map_p3_window", b3.window,
        {16'hF, 16'hE, 16'hD, 16'hB, 16'hA, 16'h9, 16'h7, 16'h6, 16'h5});
    tick();
    chk("map_drain_win_valid", b3.win_valid, 1'b0);
    chk("map_drain_window", b3.window, '0);
    while (!b3.out_valid && (cyc - hs) < 40) tick();
    chk("map_latency", cyc - hs, 8);
    chk("map_ofmap", b3.ofmap, {16'h000A, 16'h0009, 16'h0006, 16'h0005});
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    chk("map_release_out_valid", b3.out_valid, 1'b0);
    chk("map_release_in_ready", b3.in_ready, 1'b1);
    chk("map_ofmap_kept", b3.ofmap, {16'h000A, 16'h0009, 16'h0006, 16'h0005});

    // all-ones tile and kernel -> 9.0 everywhere, then backpressure in DONE
    b3.ifmap_4x4 = fill_tile(16'h3C00); b3.weight_in = fill_win(16'h3C00); b3.in_valid = 1'b1;
    tick();
    hs = cyc;
    b3.in_valid = 1'b0;
    while (!b3.out_valid && (cyc - hs) < 40) tick();
    chk("ones_latency", cyc - hs, 8);
    chk("ones_ofmap", b3.ofmap, {4{16'h4880}});
    b3.ifmap_4x4 = fill_tile(16'h4000); b3.weight_in = fill_win(16'h4000); b3.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp%0d_out_valid", i), b3.out_valid, 1'b1);
      chk($sformatf("bp%0d_in_ready", i), b3.in_ready, 1'b0);
      chk($sformatf("bp%0d_ofmap", i), b3.ofmap, {4{16'h4880}});
    end
    chk("bp_weight_kept", b3.weight_3x3, fill_win(16'h3C00));
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    chk("bp_release_out_valid", b3.out_valid, 1'b0);
    chk("bp_release_in_ready", b3.in_ready, 1'b1);
    chk("bp_release_state", d3, IDLE);

    // reset pulsed while issuing window 2
    b3.ifmap_4x4 = fill_tile(16'h4000); b3.weight_in = fill_win(16'h3C00); b3.in_valid = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    tick(); tick();
    chk("mid_win_valid_before", b3.win_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_win_valid", b3.win_valid, 1'b0);
    chk("mid_rst_window", b3.window, '0);
    chk("mid_rst_weight", b3.weight_3x3, '0);
    chk("mid_rst_ofmap", b3.ofmap, '0);
    chk("mid_rst_out_valid", b3.out_valid, 1'b0);
    chk("mid_rst_in_ready", b3.in_ready, 1'b0);
    chk("mid_rst_state", d3, IDLE);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rdy_after_edge", b3.in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b3.out_valid) seen++;
    end
    chk("mid_no_out_valid", seen, 0);
    chk("mid_no_partial_ofmap", b3.ofmap, '0);
    b3.in_valid = 1'b1;
    tick();
    hs = cyc;
    b3.in_valid = 1'b0;
    while (!b3.out_valid && (cyc - hs) < 40) tick();
    chk("post_rst_latency", cyc - hs, 8);
    chk("post_rst_ofmap", b3.ofmap, {4{16'h4C80}});
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;

    // latency parameter with back-to-back tiles
    b2b(0, 1);
    b2b(1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
